// File: rtl/lpddr2_ca_decoder.sv
// rtl/lpddr2_ca_decoder.sv - LPDDR2 CA bus command decoder with bank, timing, MR and power tracking
module lpddr2_ca_decoder #(
    parameter int         BA_BITS = 3,
    parameter int         TRCD_CK = 3,
    parameter int         TRP_CK  = 3,
    parameter logic [7:0] MR1_RST = 8'h02,
    parameter logic [7:0] MR2_RST = 8'h01
) (
    input  logic                      ck,
    input  logic                      rst_n,
    input  logic                      cke,
    input  logic                      cs_n,
    input  logic [9:0]                ca_r,
    input  logic [9:0]                ca_f,
    output logic                      cmd_valid,
    output logic [3:0]                cmd_code,
    output logic [BA_BITS-1:0]        cmd_ba,
    output logic [14:0]               cmd_row,
    output logic [11:0]               cmd_col,
    output logic                      cmd_ap,
    output logic                      cmd_ab,
    output logic [7:0]                mr_addr,
    output logic [7:0]                mr_op,
    output logic [7:0]                mr1,
    output logic [7:0]                mr2,
    output logic [(2**BA_BITS)-1:0]   bank_open,
    output logic [1:0]                pwr_state,
    output logic                      err,
    output logic [2:0]                err_code
);

    localparam int NBANKS = 2**BA_BITS;
    localparam int RCD_W  = (TRCD_CK > 1) ? $clog2(TRCD_CK) : 1;
    localparam int RP_W   = (TRP_CK > 1) ? $clog2(TRP_CK) : 1;
    localparam logic [RCD_W-1:0] RCD_LOAD = RCD_W'(TRCD_CK - 1);
    localparam logic [RP_W-1:0]  RP_LOAD  = RP_W'(TRP_CK - 1);

    // Power states
    localparam logic [1:0] PWR_NORMAL = 2'd0;
    localparam logic [1:0] PWR_PD     = 2'd1;
    localparam logic [1:0] PWR_SREF   = 2'd2;
    localparam logic [1:0] PWR_DPD    = 2'd3;

    // Command codes (0 is used internally for NOP / deselect)
    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_MRW = 4'd1;
    localparam logic [3:0] CMD_MRR = 4'd2;
    localparam logic [3:0] CMD_REF = 4'd3;
    localparam logic [3:0] CMD_ACT = 4'd4;
    localparam logic [3:0] CMD_WR  = 4'd5;
    localparam logic [3:0] CMD_RD  = 4'd6;
    localparam logic [3:0] CMD_PRE = 4'd7;
    localparam logic [3:0] CMD_BST = 4'd8;

    // Error codes
    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_ACT_OPEN  = 3'd1;
    localparam logic [2:0] ERR_RW_IDLE   = 3'd2;
    localparam logic [2:0] ERR_TRCD      = 3'd3;
    localparam logic [2:0] ERR_TRP       = 3'd4;
    localparam logic [2:0] ERR_REFAB     = 3'd5;

    logic                 r_cke_q;
    logic [1:0]           r_pwr;
    logic                 r_cmd_valid;
    logic [3:0]           r_cmd_code;
    logic [BA_BITS-1:0]   r_cmd_ba;
    logic [14:0]          r_cmd_row;
    logic [11:0]          r_cmd_col;
    logic                 r_cmd_ap;
    logic                 r_cmd_ab;
    logic [7:0]           r_mr_addr;
    logic [7:0]           r_mr_op;
    logic [7:0]           r_mr1;
    logic [7:0]           r_mr2;
    logic [NBANKS-1:0]    r_bank_open;
    logic [14:0]          r_open_row [NBANKS];
    logic [RCD_W-1:0]     r_trcd_cnt [NBANKS];
    logic [RP_W-1:0]      r_trp_cnt  [NBANKS];
    logic                 r_err;
    logic [2:0]           r_err_code;

    logic                 w_sel;
    logic [3:0]           w_code;
    logic [BA_BITS-1:0]   w_ba;
    logic [14:0]          w_row_fld;
    logic [14:0]          w_row_out;
    logic [11:0]          w_col_fld;
    logic [7:0]           w_ma;
    logic [7:0]           w_op;
    logic                 w_ab;
    logic [2:0]           w_err_code;
    logic                 w_err;
    logic                 w_ok;
    logic                 w_pd_entry;
    logic                 w_lp_exit;
    logic                 w_full_clear;

    assign w_sel     = !cs_n && r_cke_q && cke && (r_pwr == PWR_NORMAL);
    assign w_ba      = ca_r[7 +: BA_BITS];
    assign w_row_fld = {ca_f[9:8], ca_r[6:2], ca_f[7:0]};
    assign w_col_fld = {ca_f[9:1], ca_r[6:5], 1'b0};
    assign w_ma      = {ca_f[1:0], ca_r[9:4]};
    assign w_op      = ca_f[9:2];

    // Command decode from the rise-half CA word
    always_comb begin
        w_code = CMD_NOP;
        if (w_sel) begin
            case (ca_r[1:0])
                2'b10:   w_code = CMD_ACT;
                2'b01:   w_code = ca_r[2] ? CMD_RD : CMD_WR;
                2'b00:   w_code = ca_r[2] ? CMD_REF : (ca_r[3] ? CMD_MRR : CMD_MRW);
                default: begin
                    if (!ca_r[2]) begin
                        w_code = ca_r[3] ? CMD_PRE : CMD_BST;
                    end
                end
            endcase
        end
    end

    // All-bank flag lives in different bits for PRE and REF
    always_comb begin
        w_ab = 1'b0;
        if (w_code == CMD_PRE) begin
            w_ab = ca_r[4];
        end else if (w_code == CMD_REF) begin
            w_ab = ca_r[3];
        end
    end

    // Protocol checks; branch order yields the lowest applicable code
    always_comb begin
        w_err_code = ERR_NONE;
        case (w_code)
            CMD_ACT: begin
                if (r_bank_open[w_ba]) begin
                    w_err_code = ERR_ACT_OPEN;
                end else if (r_trp_cnt[w_ba] != '0) begin
                    w_err_code = ERR_TRP;
                end
            end
            CMD_RD, CMD_WR: begin
                if (!r_bank_open[w_ba]) begin
                    w_err_code = ERR_RW_IDLE;
                end else if (r_trcd_cnt[w_ba] != '0) begin
                    w_err_code = ERR_TRCD;
                end
            end
            CMD_REF: begin
                if (w_ab && (r_bank_open != '0)) begin
                    w_err_code = ERR_REFAB;
                end
            end
            default: w_err_code = ERR_NONE;
        endcase
    end

    assign w_err = (w_err_code != ERR_NONE);
    assign w_ok  = (w_code != CMD_NOP) && !w_err;

    // RD/WR carry no row bits, so report the row they actually hit
    assign w_row_out = ((w_code == CMD_RD) || (w_code == CMD_WR)) ? r_open_row[w_ba] : w_row_fld;

    assign w_pd_entry   = (r_pwr == PWR_NORMAL) && r_cke_q && !cke;
    assign w_lp_exit    = (r_pwr != PWR_NORMAL) && cke;
    // MRW 0x3F and deep power-down exit both return the device to its reset image
    assign w_full_clear = (w_ok && (w_code == CMD_MRW) && (w_ma == 8'h3F)) ||
                          (w_lp_exit && (r_pwr == PWR_DPD));

    // cke history and power state transitions
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_cke_q <= 1'b0;
            r_pwr   <= PWR_NORMAL;
        end else begin
            r_cke_q <= cke;
            if (w_pd_entry) begin
                if (!cs_n && (ca_r[2:0] == 3'b100)) begin
                    r_pwr <= PWR_SREF;
                end else if (!cs_n && (ca_r[2:0] == 3'b011)) begin
                    r_pwr <= PWR_DPD;
                end else begin
                    r_pwr <= PWR_PD;
                end
            end else if (w_lp_exit) begin
                r_pwr <= PWR_NORMAL;
            end
        end
    end

    // Registered command report; fields refresh only on a decoded command
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= CMD_NOP;
            r_cmd_ba    <= '0;
            r_cmd_row   <= '0;
            r_cmd_col   <= '0;
            r_cmd_ap    <= 1'b0;
            r_cmd_ab    <= 1'b0;
            r_mr_addr   <= '0;
            r_mr_op     <= '0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_cmd_valid <= (w_code != CMD_NOP);
            r_err       <= w_err;
            r_err_code  <= w_err_code;
            if (w_code != CMD_NOP) begin
                r_cmd_code <= w_code;
                r_cmd_ba   <= w_ba;
                r_cmd_row  <= w_row_out;
                r_cmd_col  <= w_col_fld;
                r_cmd_ap   <= ca_f[0];
                r_cmd_ab   <= w_ab;
                r_mr_addr  <= w_ma;
                r_mr_op    <= w_op;
            end
        end
    end

    // Mode registers MR1/MR2
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_mr1 <= MR1_RST;
            r_mr2 <= MR2_RST;
        end else if (w_full_clear) begin
            r_mr1 <= MR1_RST;
            r_mr2 <= MR2_RST;
        end else if (w_ok && (w_code == CMD_MRW)) begin
            if (w_ma == 8'h01) begin
                r_mr1 <= w_op;
            end else if (w_ma == 8'h02) begin
                r_mr2 <= w_op;
            end
        end
    end

    // Bank open/idle state and open row per bank
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_open <= '0;
            for (int b = 0; b < NBANKS; b++) begin
                r_open_row[b] <= '0;
            end
        end else if (w_full_clear) begin
            r_bank_open <= '0;
        end else if (w_ok && (w_code == CMD_ACT)) begin
            r_bank_open[w_ba] <= 1'b1;
            r_open_row[w_ba]  <= w_row_fld;
        end else if (w_ok && (w_code == CMD_PRE)) begin
            if (w_ab) begin
                r_bank_open <= '0;
            end else begin
                r_bank_open[w_ba] <= 1'b0;
            end
        end
    end

    // tRCD/tRP down-counters: load on ACT/PRE, otherwise count down to zero
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NBANKS; b++) begin
                r_trcd_cnt[b] <= '0;
                r_trp_cnt[b]  <= '0;
            end
        end else begin
            for (int b = 0; b < NBANKS; b++) begin
                if (w_full_clear) begin
                    r_trcd_cnt[b] <= '0;
                end else if (w_ok && (w_code == CMD_ACT) && (w_ba == BA_BITS'(b))) begin
                    r_trcd_cnt[b] <= RCD_LOAD;
                end else if (r_trcd_cnt[b] != '0) begin
                    r_trcd_cnt[b] <= r_trcd_cnt[b] - RCD_W'(1);
                end

                if (w_full_clear) begin
                    r_trp_cnt[b] <= '0;
                end else if (w_ok && (w_code == CMD_PRE) && (w_ab || (w_ba == BA_BITS'(b)))) begin
                    r_trp_cnt[b] <= RP_LOAD;
                end else if (r_trp_cnt[b] != '0) begin
                    r_trp_cnt[b] <= r_trp_cnt[b] - RP_W'(1);
                end
            end
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_code  = r_cmd_code;
    assign cmd_ba    = r_cmd_ba;
    assign cmd_row   = r_cmd_row;
    assign cmd_col   = r_cmd_col;
    assign cmd_ap    = r_cmd_ap;
    assign cmd_ab    = r_cmd_ab;
    assign mr_addr   = r_mr_addr;
    assign mr_op     = r_mr_op;
    assign mr1       = r_mr1;
    assign mr2       = r_mr2;
    assign bank_open = r_bank_open;
    assign pwr_state = r_pwr;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule

// File: tb/tb_lpddr2_ca_decoder.sv
// tb/tb_lpddr2_ca_decoder.sv - table-driven self-checking bench for lpddr2_ca_decoder
module tb_lpddr2_ca_decoder;

    logic        ck;
    logic        rst_n;
    logic        cke;
    logic        cs_n;
    logic [9:0]  ca_r;
    logic [9:0]  ca_f;
    logic        cmd_valid;
    logic [3:0]  cmd_code;
    logic [2:0]  cmd_ba;
    logic [14:0] cmd_row;
    logic [11:0] cmd_col;
    logic        cmd_ap;
    logic        cmd_ab;
    logic [7:0]  mr_addr;
    logic [7:0]  mr_op;
    logic [7:0]  mr1;
    logic [7:0]  mr2;
    logic [7:0]  bank_open;
    logic [1:0]  pwr_state;
    logic        err;
    logic [2:0]  err_code;

    int checks;
    int failures;

    lpddr2_ca_decoder dut (
        .ck        (ck),
        .rst_n     (rst_n),
        .cke       (cke),
        .cs_n      (cs_n),
        .ca_r      (ca_r),
        .ca_f      (ca_f),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_ba    (cmd_ba),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .cmd_ap    (cmd_ap),
        .cmd_ab    (cmd_ab),
        .mr_addr   (mr_addr),
        .mr_op     (mr_op),
        .mr1       (mr1),
        .mr2       (mr2),
        .bank_open (bank_open),
        .pwr_state (pwr_state),
        .err       (err),
        .err_code  (err_code)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Field selectors for the optional per-vector checks
    localparam int F_NONE = 0, F_MRA = 1, F_MROP = 2, F_MR1 = 3, F_ROW = 4,
                   F_COL = 5, F_MR2 = 6, F_BA = 7, F_AB = 8;

    typedef struct {
        string       name;
        logic        cs_n;
        logic [19:0] carf;
        logic        exp_valid;
        logic [3:0]  exp_code;
        logic [2:0]  exp_ecode;
        logic [7:0]  exp_open;
        int          f1;
        logic [15:0] v1;
        int          f2;
        logic [15:0] v2;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [19:0] e_act(input logic [2:0] ba, input logic [14:0] row);
        return {ba, row[12:8], 2'b10, row[14:13], row[7:0]};
    endfunction
    function automatic logic [19:0] e_rw(input logic [2:0] ba, input logic [11:0] col, input logic rd);
        return {ba, col[2:1], 2'b00, rd, 2'b01, col[11:3], 1'b0};
    endfunction
    function automatic logic [19:0] e_pre(input logic [2:0] ba, input logic ab);
        return {ba, 2'b00, ab, 1'b1, 1'b0, 2'b11, 10'h000};
    endfunction
    function automatic logic [19:0] e_ref(input logic ab);
        return {6'h00, ab, 1'b1, 2'b00, 10'h000};
    endfunction
    function automatic logic [19:0] e_mrw(input logic [7:0] ma, input logic [7:0] op);
        return {ma[5:0], 4'b0000, op, ma[7:6]};
    endfunction
    function automatic logic [19:0] e_mrr(input logic [7:0] ma);
        return {ma[5:0], 4'b1000, 10'h000};
    endfunction
    localparam logic [19:0] E_NOP = {10'h007, 10'h000};
    localparam logic [19:0] E_BST = {10'h003, 10'h000};

    function automatic vec_t mk(input string n, input logic c, input logic [19:0] cf,
                                input logic v, input logic [3:0] code, input logic [2:0] ec,
                                input logic [7:0] op, input int f1, input logic [15:0] v1,
                                input int f2, input logic [15:0] v2);
        vec_t t;
        t.name = n; t.cs_n = c; t.carf = cf; t.exp_valid = v; t.exp_code = code;
        t.exp_ecode = ec; t.exp_open = op; t.f1 = f1; t.v1 = v1; t.f2 = f2; t.v2 = v2;
        return t;
    endfunction

    function automatic logic [15:0] get_fld(input int f);
        case (f)
            F_MRA:   return {8'h00, mr_addr};
            F_MROP:  return {8'h00, mr_op};
            F_MR1:   return {8'h00, mr1};
            F_ROW:   return {1'b0, cmd_row};
            F_COL:   return {4'h0, cmd_col};
            F_MR2:   return {8'h00, mr2};
            F_BA:    return {13'h0000, cmd_ba};
            F_AB:    return {15'h0000, cmd_ab};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic drive(input logic k, input logic c, input logic [19:0] cf);
        @(negedge ck);
        cke  = k;
        cs_n = c;
        ca_r = cf[19:10];
        ca_f = cf[9:0];
        @(posedge ck);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        cke   = 1'b1;
        cs_n  = 1'b1;
        ca_r  = 10'h007;
        ca_f  = 10'h000;

        vecs.push_back(mk("nop_after_reset", 0, E_NOP,                        0, 0, 0, 8'h00, F_NONE, 0, F_NONE, 0));
        vecs.push_back(mk("mrw_mr1",         0, e_mrw(8'h01, 8'h52),          1, 1, 0, 8'h00, F_MRA, 16'h01, F_MROP, 16'h52));
        vecs.push_back(mk("mr1_loaded",      0, E_NOP,                        0, 0, 0, 8'h00, F_MR1, 16'h52, F_NONE, 0));
        vecs.push_back(mk("act_b2",          0, e_act(3'd2, 15'h1234),        1, 4, 0, 8'h04, F_ROW, 16'h1234, F_BA, 16'h2));
        vecs.push_back(mk("gap",             0, E_NOP,                        0, 0, 0, 8'h04, F_NONE, 0, F_NONE, 0));
        vecs.push_back(mk("rd_trcd_viol",    0, e_rw(3'd2, 12'h040, 1'b1),    1, 6, 3, 8'h04, F_NONE, 0, F_NONE, 0));
        vecs.push_back(mk("rd_trcd_ok",      0, e_rw(3'd2, 12'h040, 1'b1),    1, 6, 0, 8'h04, F_COL, 16'h040, F_ROW, 16'h1234));
        vecs.push_back(mk("rd_idle_b5",      0, e_rw(3'd5, 12'h000, 1'b1),    1, 6, 2, 8'h04, F_NONE, 0, F_NONE, 0));
        vecs.push_back(mk("act_open_b2",     0, e_act(3'd2, 15'h0555),        1, 4, 1, 8'h04, F_NONE, 0, F_NONE, 0));
        vecs.push_back(mk("pre_b2",          0, e_pre(3'd2, 1'b0),            1, 7, 0, 8'h00, F_AB, 16'h0, F_NONE, 0));
        vecs.push_back(mk("gap2",            0, E_NOP,                        0, 0, 0, 8'h00, F_NONE, 0, F_NONE, 0));
        vecs.push_back(mk("act_trp_viol",    0, e_act(3'd2, 15'h1234),        1, 4, 4, 8'h00, F_NONE, 0, F_NONE, 0));
        vecs.push_back(mk("act_trp_ok",      0, e_act(3'd2, 15'h1234),        1, 4, 0, 8'h04, F_ROW, 16'h1234, F_NONE, 0));
        vecs.push_back(mk("refab_open",      0, e_ref(1'b1),                  1, 3, 5, 8'h04, F_AB, 16'h1, F_NONE, 0));
        vecs.push_back(mk("preab",           0, e_pre(3'd0, 1'b1),            1, 7, 0, 8'h00, F_AB, 16'h1, F_NONE, 0));
        vecs.push_back(mk("refab_ok",        0, e_ref(1'b1),                  1, 3, 0, 8'h00, F_AB, 16'h1, F_NONE, 0));
        vecs.push_back(mk("deselect",        1, e_act(3'd4, 15'h0001),        0, 0, 0, 8'h00, F_NONE, 0, F_NONE, 0));
        vecs.push_back(mk("mrr_5",           0, e_mrr(8'h05),                 1, 2, 0, 8'h00, F_MRA, 16'h05, F_MR1, 16'h52));
        vecs.push_back(mk("bst",             0, E_BST,                        1, 8, 0, 8'h00, F_NONE, 0, F_NONE, 0));
        vecs.push_back(mk("mrw_mr2",         0, e_mrw(8'h02, 8'hA5),          1, 1, 0, 8'h00, F_MROP, 16'hA5, F_NONE, 0));
        vecs.push_back(mk("wr_idle_b3",      0, e_rw(3'd3, 12'h008, 1'b0),    1, 5, 2, 8'h00, F_COL, 16'h008, F_MR2, 16'hA5));
        vecs.push_back(mk("act_b1",          0, e_act(3'd1, 15'h7FFF),        1, 4, 0, 8'h02, F_ROW, 16'h7FFF, F_NONE, 0));
        vecs.push_back(mk("pre_b1",          0, e_pre(3'd1, 1'b0),            1, 7, 0, 8'h00, F_NONE, 0, F_NONE, 0));
        vecs.push_back(mk("mrw_3f",          0, e_mrw(8'h3F, 8'h00),          1, 1, 0, 8'h00, F_MRA, 16'h3F, F_NONE, 0));
        vecs.push_back(mk("act_after_3f",    0, e_act(3'd1, 15'h0000),        1, 4, 0, 8'h02, F_MR1, 16'h02, F_MR2, 16'h01));

        repeat (3) @(posedge ck);
        #1;
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_err",       err,       0);
        chk("rst_cmd_code",  cmd_code,  0);
        chk("rst_mr1",       mr1,       8'h02);
        chk("rst_mr2",       mr2,       8'h01);
        chk("rst_bank_open", bank_open, 0);
        chk("rst_pwr",       pwr_state, 0);
        @(negedge ck);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(1'b1, vecs[i].cs_n, vecs[i].carf);
            chk({vecs[i].name, "_valid"}, cmd_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) chk({vecs[i].name, "_code"}, cmd_code, vecs[i].exp_code);
            chk({vecs[i].name, "_err"}, err, (vecs[i].exp_ecode != 0));
            chk({vecs[i].name, "_ecode"}, err_code, vecs[i].exp_ecode);
            chk({vecs[i].name, "_open"}, bank_open, vecs[i].exp_open);
            chk({vecs[i].name, "_pwr"}, pwr_state, 0);
            if (vecs[i].f1 != F_NONE) chk({vecs[i].name, "_f1"}, get_fld(vecs[i].f1), vecs[i].v1);
            if (vecs[i].f2 != F_NONE) chk({vecs[i].name, "_f2"}, get_fld(vecs[i].f2), vecs[i].v2);
        end

        // Self refresh: entry with REF encoding, exit keeps bank 1 open
        drive(1'b0, 1'b0, e_ref(1'b0));
        chk("sref_entry_pwr", pwr_state, 2);
        chk("sref_entry_valid", cmd_valid, 0);
        drive(1'b0, 1'b0, e_act(3'd3, 15'h0005));
        chk("sref_hold_pwr", pwr_state, 2);
        chk("sref_hold_valid", cmd_valid, 0);
        drive(1'b1, 1'b0, e_act(3'd3, 15'h0005));
        chk("sref_exit_pwr", pwr_state, 0);
        chk("sref_exit_valid", cmd_valid, 0);
        chk("sref_exit_open", bank_open, 8'h02);
        drive(1'b1, 1'b0, e_act(3'd3, 15'h0005));
        chk("post_sref_act_valid", cmd_valid, 1);
        chk("post_sref_act_open", bank_open, 8'h0A);

        // Deep power-down: exit restores MRs and closes banks
        drive(1'b1, 1'b0, e_mrw(8'h01, 8'h77));
        drive(1'b1, 1'b0, E_NOP);
        chk("pre_dpd_mr1", mr1, 8'h77);
        drive(1'b0, 1'b0, E_BST);
        chk("dpd_entry_pwr", pwr_state, 3);
        chk("dpd_entry_valid", cmd_valid, 0);
        drive(1'b0, 1'b0, e_rw(3'd1, 12'h000, 1'b1));
        chk("dpd_hold_err", err, 0);
        drive(1'b1, 1'b0, E_NOP);
        chk("dpd_exit_pwr", pwr_state, 0);
        chk("dpd_exit_valid", cmd_valid, 0);
        chk("dpd_exit_mr1", mr1, 8'h02);
        chk("dpd_exit_open", bank_open, 0);

        // Plain power-down via deselect, then a command after exit
        drive(1'b1, 1'b1, E_NOP);
        drive(1'b0, 1'b1, E_NOP);
        chk("pd_entry_pwr", pwr_state, 1);
        drive(1'b1, 1'b1, E_NOP);
        chk("pd_exit_pwr", pwr_state, 0);
        drive(1'b1, 1'b0, e_mrw(8'h01, 8'h33));
        chk("post_pd_mrw_valid", cmd_valid, 1);
        chk("post_pd_mrw_code", cmd_code, 1);
        drive(1'b1, 1'b0, e_act(3'd0, 15'h0010));
        chk("pre_rst_open", bank_open, 8'h01);
        chk("pre_rst_mr1", mr1, 8'h33);

        // Reset asserted together with a command: reset wins
        @(negedge ck);
        rst_n = 1'b0;
        cs_n  = 1'b0;
        cke   = 1'b1;
        ca_r  = e_act(3'd4, 15'h0001) >> 10;
        @(posedge ck);
        #1;
        chk("rst_win_valid", cmd_valid, 0);
        chk("rst_win_open", bank_open, 0);
        chk("rst_win_mr1", mr1, 8'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
